nrs_rd_arbiter: RTL and testbench

NRS_RD_ARBITER -- requirements
Module: nrs_rd_arbiter

---
 rtl/nrs_rd_arbiter_if.sv | 38 +++
 rtl/nrs_rd_arbiter.sv | 138 +++++++++++++
 tb/tb_nrs_rd_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrs_rd_arbiter_if.sv
// Read-port bundle between the NRS slot register, its two readers (channel
// estimator, fine sync) and the read arbiter that sits between them.
interface nrs_rd_arbiter_if #(
  parameter int LINES = 4
);
  logic             NRS_gen_ready;
  logic             fine_en;
  logic             req_est;
  logic             req_fine;
  logic [LINES-1:0] addr_est;
  logic [LINES-1:0] addr_fine;
  logic             done_est;
  logic             done_fine;
  logic             nrs_rd_bit;
  logic [LINES-1:0] rd_addr;
  logic             gnt_est;
  logic             gnt_fine;
  logic             nrs_data;
  logic             vld_est;
  logic             vld_fine;
  logic             est_ack;
  logic             overrun;

  // Environment side: generator, requesters and the register read port.
  modport master (
    output NRS_gen_ready, fine_en, req_est, req_fine, addr_est, addr_fine,
           done_est, done_fine, nrs_rd_bit,
    input  rd_addr, gnt_est, gnt_fine, nrs_data, vld_est, vld_fine,
           est_ack, overrun
  );

  modport slave (
    input  NRS_gen_ready, fine_en, req_est, req_fine, addr_est, addr_fine,
           done_est, done_fine, nrs_rd_bit,
    output rd_addr, gnt_est, gnt_fine, nrs_data, vld_est, vld_fine,
           est_ack, overrun
  );
endinterface

// File: rtl/nrs_rd_arbiter.sv
// Two-requester read arbiter for the NRS slot register: round-robin grants
// within a slot, released by both done flags or by a forced timeout.
module nrs_rd_arbiter #(
  parameter int LINES   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  nrs_rd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             fine_en_q, fine_en_d;
  logic             done_est_q, done_est_d;
  logic             done_fine_q, done_fine_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             prio_fine_q, prio_fine_d;
  logic [LINES-1:0] rd_addr_q, rd_addr_d;
  logic             nrs_data_q;
  logic             vld_est_q, vld_fine_q;
  logic             est_ack_q, est_ack_d;
  logic             overrun_q, overrun_d;
  logic             req_fine_m;
  logic             gnt_est_c, gnt_fine_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fine_en_q   <= 1'b0;
      done_est_q  <= 1'b0;
      done_fine_q <= 1'b0;
      cnt_q       <= 16'd0;
      prio_fine_q <= 1'b0;
      rd_addr_q   <= '0;
      nrs_data_q  <= 1'b0;
      vld_est_q   <= 1'b0;
      vld_fine_q  <= 1'b0;
      est_ack_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fine_en_q   <= fine_en_d;
      done_est_q  <= done_est_d;
      done_fine_q <= done_fine_d;
      cnt_q       <= cnt_d;
      prio_fine_q <= prio_fine_d;
      rd_addr_q   <= rd_addr_d;
      nrs_data_q  <= bus.nrs_rd_bit;
      vld_est_q   <= gnt_est_c;
      vld_fine_q  <= gnt_fine_c;
      est_ack_q   <= est_ack_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic; done flags include this cycle's pulse so release
  // happens on the very next edge.
  always_comb begin
    state_d     = state_q;
    fine_en_d   = fine_en_q;
    done_est_d  = done_est_q;
    done_fine_d = done_fine_q;
    cnt_d       = cnt_q;
    est_ack_d   = 1'b0;
    overrun_d   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.NRS_gen_ready) begin
          state_d     = ST_SERVE;
          fine_en_d   = bus.fine_en;
          done_est_d  = 1'b0;
          done_fine_d = 1'b0;
          cnt_d       = 16'd0;
        end
      end
      ST_SERVE: begin
        done_est_d  = done_est_q | bus.done_est;
        done_fine_d = done_fine_q | bus.done_fine | ~fine_en_q;
        if (done_est_d && done_fine_d) begin
          state_d   = ST_RELEASE;
          est_ack_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RELEASE;
          est_ack_d = 1'b1;
          overrun_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (!bus.NRS_gen_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: grants are combinational so an asynchronous reset drops
  // them in the same instant; the tie goes to whoever was not served last.
  always_comb begin
    req_fine_m = bus.req_fine & fine_en_q;
    gnt_est_c  = 1'b0;
    gnt_fine_c = 1'b0;
    if (state_q == ST_SERVE) begin
      if (bus.req_est && req_fine_m) begin
        gnt_fine_c = prio_fine_q;
        gnt_est_c  = ~prio_fine_q;
      end else begin
        gnt_est_c  = bus.req_est;
        gnt_fine_c = req_fine_m;
      end
    end

    rd_addr_d = rd_addr_q;
    if (gnt_est_c)       rd_addr_d = bus.addr_est;
    else if (gnt_fine_c) rd_addr_d = bus.addr_fine;

    prio_fine_d = prio_fine_q;
    if (gnt_est_c)       prio_fine_d = 1'b1;
    else if (gnt_fine_c) prio_fine_d = 1'b0;
  end

  assign bus.gnt_est  = gnt_est_c;
  assign bus.gnt_fine = gnt_fine_c;
  assign bus.rd_addr  = rd_addr_d;
  assign bus.nrs_data = nrs_data_q;
  assign bus.vld_est  = vld_est_q;
  assign bus.vld_fine = vld_fine_q;
  assign bus.est_ack  = est_ack_q;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_nrs_rd_arbiter.sv
// Bench for nrs_rd_arbiter: a long-timeout and a short-timeout instance share
// stimulus and are both compared every cycle against a slot-level model.
`timescale 1ns/1ps
module tb_nrs_rd_arbiter;
  localparam int LINES    = 4;
  localparam int TO_MAIN  = 1024;
  localparam int TO_SHORT = 8;
  localparam int IDLE = 0, SERVE = 1, REL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0, fen = 1'b0, re = 1'b0, rf = 1'b0, de = 1'b0, df = 1'b0;
  logic [3:0]  ae = 4'd0, af = 4'd0;
  logic [15:0] nrs_reg = 16'h0;
  int          n_chk = 0;
  int          n_fail = 0;

  nrs_rd_arbiter_if #(.LINES(LINES)) bus0 ();
  nrs_rd_arbiter_if #(.LINES(LINES)) bus1 ();

  assign bus0.NRS_gen_ready = ready;
  assign bus0.fine_en       = fen;
  assign bus0.req_est       = re;
  assign bus0.req_fine      = rf;
  assign bus0.addr_est      = ae;
  assign bus0.addr_fine     = af;
  assign bus0.done_est      = de;
  assign bus0.done_fine     = df;
  assign bus0.nrs_rd_bit    = nrs_reg[bus0.rd_addr];
  assign bus1.NRS_gen_ready = ready;
  assign bus1.fine_en       = fen;
  assign bus1.req_est       = re;
  assign bus1.req_fine      = rf;
  assign bus1.addr_est      = ae;
  assign bus1.addr_fine     = af;
  assign bus1.done_est      = de;
  assign bus1.done_fine     = df;
  assign bus1.nrs_rd_bit    = nrs_reg[bus1.rd_addr];

  nrs_rd_arbiter #(.LINES(LINES), .TIMEOUT(TO_MAIN)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  nrs_rd_arbiter #(.LINES(LINES), .TIMEOUT(TO_SHORT)) u_dut_short (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Slot-level reference model, one entry per instance.
  int m_st[2];
  int m_served[2];
  int m_addr[2];
  int tmo[2] = '{TO_MAIN, TO_SHORT};
  bit m_fine[2], m_de[2], m_df[2], m_pf[2];
  bit m_ve[2], m_vf[2], m_dat[2], m_ack[2], m_ovr[2];

  function automatic bit m_ge(int k);
    return (m_st[k] == SERVE) && re && !(rf && m_fine[k] && m_pf[k]);
  endfunction

  function automatic bit m_gf(int k);
    return (m_st[k] == SERVE) && rf && m_fine[k] && !m_ge(k);
  endfunction

  function automatic int m_rd(int k);
    if (m_ge(k)) return int'(ae);
    if (m_gf(k)) return int'(af);
    return m_addr[k];
  endfunction

  function automatic logic [10:0] exp_out(int k);
    return {m_ge(k), m_gf(k), 4'(m_rd(k)), m_ve[k], m_vf[k], m_dat[k], m_ack[k], m_ovr[k]};
  endfunction

  function automatic logic [10:0] obs(int k);
    if (k == 0)
      return {bus0.gnt_est, bus0.gnt_fine, bus0.rd_addr, bus0.vld_est, bus0.vld_fine,
              bus0.nrs_data, bus0.est_ack, bus0.overrun};
    return {bus1.gnt_est, bus1.gnt_fine, bus1.rd_addr, bus1.vld_est, bus1.vld_fine,
            bus1.nrs_data, bus1.est_ack, bus1.overrun};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = IDLE; m_served[k] = 0; m_addr[k] = 0;
      m_fine[k] = 0; m_de[k] = 0; m_df[k] = 0; m_pf[k] = 0;
      m_ve[k] = 0; m_vf[k] = 0; m_dat[k] = 0; m_ack[k] = 0; m_ovr[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit ge, gf;
      int a;
      ge = m_ge(k);
      gf = m_gf(k);
      a  = m_rd(k);
      m_dat[k]  = nrs_reg[a];
      m_addr[k] = a;
      m_ve[k]   = ge;
      m_vf[k]   = gf;
      if (ge) m_pf[k] = 1'b1;
      else if (gf) m_pf[k] = 1'b0;
      m_ack[k] = 1'b0;
      case (m_st[k])
        IDLE: if (ready) begin
          m_st[k] = SERVE; m_fine[k] = fen; m_de[k] = 0; m_df[k] = 0; m_served[k] = 0;
        end
        SERVE: begin
          m_served[k] = m_served[k] + 1;
          m_de[k] = m_de[k] | de;
          m_df[k] = m_df[k] | df | !m_fine[k];
          if (m_de[k] && m_df[k]) begin
            m_st[k] = REL; m_ack[k] = 1'b1;
          end else if (m_served[k] >= tmo[k]) begin
            m_st[k] = REL; m_ack[k] = 1'b1; m_ovr[k] = 1'b1;
          end
        end
        default: if (!ready) m_st[k] = IDLE;
      endcase
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_slot();
    re = 0; rf = 0; de = 1; df = 1;
    cycle();
    de = 0; df = 0; ready = 0;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    rst = 0; ready = 0; fen = 0; re = 0; rf = 0; de = 0; df = 0;
    nrs_reg = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs(k) !== 11'h0) begin
        n_fail++; $display("FAIL reset_outputs[%0d] got %h want %h", k, obs(k), 11'h0);
      end
    end
    ready = 1; re = 1; fen = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs(k) !== 11'h0) begin
        n_fail++; $display("FAIL reset_dominates[%0d] got %h want %h", k, obs(k), 11'h0);
      end
    end
    ready = 0; re = 0; fen = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL reset_idle[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      cycle();
    end
  endtask

  task automatic test_timeout();
    int first_ack;
    first_ack = 0;
    nrs_reg = 16'h3C5A;
    fen = 1; ready = 1;
    cycle();
    for (int n = 1; n <= 12; n++) begin
      de = (n == 2);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL timeout_model[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      if (bus1.est_ack === 1'b1 && first_ack == 0) first_ack = n;
      cycle();
    end
    de = 0;
    n_chk++;
    if (first_ack != 9) begin
      n_fail++; $display("FAIL timeout_ack_cycle got %0d want %0d", first_ack, 9);
    end
    n_chk++;
    if (bus1.overrun !== 1'b1 || bus0.overrun !== 1'b0) begin
      n_fail++; $display("FAIL timeout_overrun got %b%b want 10", bus1.overrun, bus0.overrun);
    end
    df = 1;
    cycle();
    df = 0; ready = 0;
    repeat (2) cycle();
    ready = 1; fen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_chk++;
      if (bus1.overrun !== 1'b1) begin
        n_fail++; $display("FAIL overrun_sticky got %b want 1", bus1.overrun);
      end
      cycle();
    end
    finish_slot();
  endtask

  task automatic test_basic_est();
    logic [15:0] pat;
    int acks;
    pat = 16'hA5C3;
    nrs_reg = pat;
    acks = 0;
    fen = 0; ready = 1;
    cycle();
    for (int i = 0; i <= 16; i++) begin
      re = (i < 16);
      ae = 4'(i);
      de = (i == 16);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL basic_model[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      if (i > 0) begin
        n_chk++;
        if (bus0.vld_est !== 1'b1 || bus0.nrs_data !== pat[i-1]) begin
          n_fail++; $display("FAIL basic_data addr %0d got vld=%b d=%b want vld=1 d=%b",
                             i - 1, bus0.vld_est, bus0.nrs_data, pat[i-1]);
        end
      end
      cycle();
    end
    re = 0; de = 0;
    for (int n = 0; n < 5; n++) begin
      ready = (n < 2);
      @(negedge clk);
      if (bus0.est_ack === 1'b1) acks++;
      cycle();
    end
    n_chk++;
    if (acks != 1) begin
      n_fail++; $display("FAIL basic_ack_count got %0d want 1", acks);
    end
    re = 1;
    @(negedge clk);
    n_chk++;
    if (bus0.gnt_est !== 1'b0 || obs(0) !== exp_out(0)) begin
      n_fail++; $display("FAIL basic_back_idle got %h want %h", obs(0), exp_out(0));
    end
    cycle();
    re = 0;
  endtask

  task automatic test_contention();
    logic prev_ge;
    prev_ge = 1'b0;
    fen = 1; ready = 1;
    cycle();
    re = 1; rf = 1; ae = 4'd3; af = 4'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL contention_model[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      n_chk++;
      if ((bus0.gnt_est ^ bus0.gnt_fine) !== 1'b1 || (i > 0 && bus0.gnt_est === prev_ge) ||
          bus0.rd_addr !== (bus0.gnt_est ? 4'd3 : 4'd7)) begin
        n_fail++; $display("FAIL contention_alternate i=%0d got ge=%b gf=%b addr=%0d prev_ge=%b",
                           i, bus0.gnt_est, bus0.gnt_fine, bus0.rd_addr, prev_ge);
      end
      prev_ge = bus0.gnt_est;
      cycle();
    end
    finish_slot();
  endtask

  task automatic test_done_order();
    fen = 1; ready = 1;
    cycle();
    for (int n = 0; n < 6; n++) begin
      df = (n == 0);
      de = (n == 3);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL done_order_model[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      n_chk++;
      if (bus0.est_ack !== (n == 4)) begin
        n_fail++; $display("FAIL done_order_ack n=%0d got %b want %b", n, bus0.est_ack, (n == 4));
      end
      cycle();
    end
    de = 0; df = 0; ready = 0;
    repeat (2) cycle();
  endtask

  task automatic test_ignored();
    ready = 0;
    for (int n = 0; n < 10; n++) begin
      re = 1'($urandom); rf = 1'($urandom); de = 1'($urandom); df = 1'($urandom);
      fen = 1'($urandom); ae = 4'($urandom); af = 4'($urandom);
      @(negedge clk);
      n_chk++;
      if ({bus0.gnt_est, bus0.gnt_fine, bus0.est_ack, bus1.gnt_est, bus1.gnt_fine, bus1.est_ack} !== 6'b0
          || obs(0) !== exp_out(0)) begin
        n_fail++; $display("FAIL ignored_idle n=%0d got %h want %h", n, obs(0), exp_out(0));
      end
      cycle();
    end
    re = 0; rf = 0; df = 0; de = 0; fen = 0; ready = 1;
    cycle();
    for (int n = 0; n < 4; n++) begin
      de = 1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL ignored_model[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      n_chk++;
      if (bus0.est_ack !== (n == 1)) begin
        n_fail++; $display("FAIL release_single_ack n=%0d got %b want %b", n, bus0.est_ack, (n == 1));
      end
      cycle();
    end
    de = 0; ready = 0;
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid_serve();
    fen = 1; ready = 1;
    cycle();
    re = 1; ae = 4'd5;
    cycle();
    n_chk++;
    if (bus0.gnt_est !== 1'b1 || bus0.vld_est !== 1'b1) begin
      n_fail++; $display("FAIL mid_serve_setup got ge=%b ve=%b want 1 1", bus0.gnt_est, bus0.vld_est);
    end
    #1 rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs(k) !== 11'h0) begin
        n_fail++; $display("FAIL mid_serve_reset[%0d] got %h want %h", k, obs(k), 11'h0);
      end
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1; re = 1; rf = 1; ae = 4'd2; af = 4'd9;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL post_reset_model[%0d] t=%0t got %h want %h", k, $time, obs(k), exp_out(k));
        end
      end
      if (n == 1) begin
        n_chk++;
        if (bus0.gnt_est !== 1'b1 || bus0.gnt_fine !== 1'b0) begin
          n_fail++; $display("FAIL post_reset_est_priority got ge=%b gf=%b want 1 0", bus0.gnt_est, bus0.gnt_fine);
        end
      end
      cycle();
    end
    finish_slot();
  endtask

  task automatic test_random();
    nrs_reg = 16'($urandom);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 11) == 0) ready = ~ready;
      fen = 1'($urandom);
      re  = 1'($urandom);
      rf  = 1'($urandom);
      ae  = 4'($urandom);
      af  = 4'($urandom);
      de  = ($urandom_range(0, 7) == 0);
      df  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs(k) !== exp_out(k)) begin
          n_fail++; $display("FAIL random_model[%0d] n=%0d got %h want %h", k, n, obs(k), exp_out(k));
        end
      end
      cycle();
    end
    finish_slot();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timeout();
    test_basic_est();
    test_contention();
    test_done_order();
    test_ignored();
    test_reset_mid_serve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
